// File: rtl/data_regbank.sv
// data_regbank: 16-word register bank feeding the data-memory read mux, with registered select and sequential clear
module data_regbank #(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WR_EN,
   input  logic [3:0]       WR_ADDR,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             RD_REQ,
   input  logic [3:0]       RD_ADDR,
   input  logic             CLR_REQ,
   output logic [3:0]       SEL,
   output logic             RD_VALID,
   output logic             BUSY,
   output logic [WIDTH-1:0] Q0,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Q2,
   output logic [WIDTH-1:0] Q3,
   output logic [WIDTH-1:0] Q4,
   output logic [WIDTH-1:0] Q5,
   output logic [WIDTH-1:0] Q6,
   output logic [WIDTH-1:0] Q7,
   output logic [WIDTH-1:0] Q8,
   output logic [WIDTH-1:0] Q9,
   output logic [WIDTH-1:0] Q10,
   output logic [WIDTH-1:0] Q11,
   output logic [WIDTH-1:0] Q12,
   output logic [WIDTH-1:0] Q13,
   output logic [WIDTH-1:0] Q14,
   output logic [WIDTH-1:0] Q15
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t           state, state_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [WIDTH-1:0] mem [16];
   logic             idle_go, wr_go, rd_go;
   // Requests are only honoured in IDLE, and a clear request pre-empts both
   assign idle_go = (state == IDLE) && !CLR_REQ;
   assign wr_go   = idle_go && WR_EN;
   assign rd_go   = idle_go && RD_REQ;
   assign BUSY    = (state == CLEAR);
   // State and clear-counter registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   // Next state: enter CLEAR on request, walk all 16 words, leave after word 15 (counter wraps to 0)
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         if (CLR_REQ) begin
            state_nx = CLEAR;
            cnt_nx   = '0;
         end
      end else begin
         cnt_nx   = cnt + 4'd1;
         state_nx = (cnt == 4'd15) ? IDLE : CLEAR;
      end
   end
   // Word storage: one word cleared per cycle during CLEAR, otherwise single-cycle writes
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (state == CLEAR) begin
         mem[cnt] <= CLR_VAL;
      end else if (wr_go) begin
         mem[WR_ADDR] <= WR_DATA;
      end
   end
   // Read select and strobe land on the same edge as any write, giving write-first behaviour
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         SEL      <= '0;
         RD_VALID <= 1'b0;
      end else begin
         RD_VALID <= rd_go;
         if (rd_go) SEL <= RD_ADDR;
      end
   end
   assign Q0  = mem[0];
   assign Q1  = mem[1];
   assign Q2  = mem[2];
   assign Q3  = mem[3];
   assign Q4  = mem[4];
   assign Q5  = mem[5];
   assign Q6  = mem[6];
   assign Q7  = mem[7];
   assign Q8  = mem[8];
   assign Q9  = mem[9];
   assign Q10 = mem[10];
   assign Q11 = mem[11];
   assign Q12 = mem[12];
   assign Q13 = mem[13];
   assign Q14 = mem[14];
   assign Q15 = mem[15];
endmodule

// File: tb/tb_data_regbank.sv
// tb_data_regbank: directed stimulus with a behavioural reference model checked every cycle
module tb_data_regbank;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        clr_req = 1'b0;
   logic [3:0]  sel;
   logic        rd_valid, busy;
   logic [15:0] q [16];
   int checks = 0;
   int errors = 0;
   // reference model state
   logic [15:0] m_q [16];
   logic [3:0]  m_sel;
   logic        m_valid;
   int          m_left;
   data_regbank #(.WIDTH(16), .CLR_VAL(16'h0000)) dut (
      .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .RD_REQ(rd_req), .RD_ADDR(rd_addr), .CLR_REQ(clr_req),
      .SEL(sel), .RD_VALID(rd_valid), .BUSY(busy),
      .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]), .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
      .Q8(q[8]), .Q9(q[9]), .Q10(q[10]), .Q11(q[11]), .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15])
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: a clear is "words remaining"; word index = 16 - remaining
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_q[i] = 16'h0000;
         m_sel = 4'd0;
         m_valid = 1'b0;
         m_left = 0;
      end else if (m_left > 0) begin
         m_q[16 - m_left] = 16'h0000;
         m_left = m_left - 1;
         m_valid = 1'b0;
      end else if (clr_req) begin
         m_left = 16;
         m_valid = 1'b0;
      end else begin
         if (wr_en) m_q[wr_addr] = wr_data;
         m_valid = rd_req;
         if (rd_req) m_sel = rd_addr;
      end
   end
   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) check($sformatf("model_q%0d", i), q[i], m_q[i]);
      check("model_sel", sel, m_sel);
      check("model_rd_valid", rd_valid, m_valid);
      check("model_busy", busy, m_left > 0);
   end
   task automatic cyc(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic rr, input logic [3:0] ra, input logic cr);
      wr_en = we; wr_addr = wa; wr_data = wd; rd_req = rr; rd_addr = ra; clr_req = cr;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_req = 1'b0; clr_req = 1'b0;
   endtask
   task automatic check_all_q(input string name, input logic [15:0] exp);
      for (int i = 0; i < 16; i++) check($sformatf("%s_q%0d", name, i), q[i], exp);
   endtask
   initial begin
      #22 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all_q("reset", 16'h0000);
      check("reset_sel", sel, 4'd0);
      check("reset_valid", rd_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      // write then read
      cyc(1, 4'd3, 16'hA5A5, 0, 4'd0, 0);
      cyc(0, 4'd0, 16'h0000, 1, 4'd3, 0);
      check("wr_rd_sel", sel, 4'd3);
      check("wr_rd_valid", rd_valid, 1'b1);
      check("wr_rd_q3", q[3], 16'hA5A5);
      check("wr_rd_q4", q[4], 16'h0000);
      cyc(0, 4'd0, 16'h0000, 0, 4'd0, 0);
      check("valid_pulse_end", rd_valid, 1'b0);
      check("sel_hold", sel, 4'd3);
      // write-first collision
      cyc(1, 4'd7, 16'hFFFF, 0, 4'd0, 0);
      cyc(1, 4'd7, 16'h1234, 1, 4'd7, 0);
      check("coll_sel", sel, 4'd7);
      check("coll_valid", rd_valid, 1'b1);
      check("coll_q7", q[7], 16'h1234);
      // back-to-back reads
      cyc(0, 4'd0, 16'h0000, 1, 4'd1, 0);
      check("b2b_valid1", rd_valid, 1'b1);
      cyc(0, 4'd0, 16'h0000, 1, 4'd2, 0);
      check("b2b_valid2", rd_valid, 1'b1);
      check("b2b_sel2", sel, 4'd2);
      // clear sequence
      for (int i = 0; i < 16; i++) cyc(1, 4'(i), 16'hBEEF, 0, 4'd0, 0);
      check_all_q("preload", 16'hBEEF);
      cyc(0, 4'd0, 16'h0000, 0, 4'd0, 1);
      for (int k = 1; k <= 16; k++) begin
         check($sformatf("clr_busy_%0d", k), busy, 1'b1);
         if (k == 1) begin
            cyc(1, 4'd0, 16'h5555, 1, 4'd4, 0);
            check("clr_rd_dropped", rd_valid, 1'b0);
            check("clr_sel_hold", sel, 4'd2);
         end else cyc(0, 4'd0, 16'h0000, 0, 4'd0, 0);
         if (k == 6) begin
            check("clr_q5_cleared", q[5], 16'h0000);
            check("clr_q6_pending", q[6], 16'hBEEF);
         end
      end
      check("clr_busy_done", busy, 1'b0);
      check("clr_wr_dropped_q0", q[0], 16'h0000);
      check_all_q("clr_done", 16'h0000);
      // priority of CLR_REQ over write/read
      cyc(1, 4'd2, 16'h2222, 1, 4'd4, 0);
      cyc(1, 4'd2, 16'h7777, 1, 4'd9, 1);
      check("prio_q2", q[2], 16'h2222);
      check("prio_valid", rd_valid, 1'b0);
      check("prio_sel", sel, 4'd4);
      check("prio_busy", busy, 1'b1);
      for (int k = 0; k < 16; k++) cyc(0, 4'd0, 16'h0000, 0, 4'd0, 0);
      check("prio_busy_done", busy, 1'b0);
      check("prio_q2_cleared", q[2], 16'h0000);
      // reset mid-clear
      cyc(1, 4'd15, 16'hABCD, 0, 4'd0, 0);
      cyc(1, 4'd14, 16'h1357, 0, 4'd0, 0);
      cyc(0, 4'd0, 16'h0000, 0, 4'd0, 1);
      for (int k = 0; k < 7; k++) cyc(0, 4'd0, 16'h0000, 0, 4'd0, 0);
      check("midclr_busy_before", busy, 1'b1);
      check("midclr_q15_before", q[15], 16'hABCD);
      #3 rst_n = 1'b0;
      #1;
      check("midclr_busy", busy, 1'b0);
      check("midclr_sel", sel, 4'd0);
      check_all_q("midclr", 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 4'd15, 16'h00FF, 1, 4'd15, 0);
      check("post_rst_q15", q[15], 16'h00FF);
      check("post_rst_sel", sel, 4'd15);
      check("post_rst_valid", rd_valid, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_regbank.md
Name: data_regbank

Overview:
16-word data-memory storage bank for the 16-bit RISC processor. It sits directly upstream of the data-memory read multiplexer. It holds the word registers that drive the mux's sixteen data inputs, and it drives the mux select from a registered read address. It also provides single-cycle writes, a registered read strobe, and a sequential whole-memory clear with a BUSY indication.

Parameters:
WIDTH, 16, data word width in bits (Q0..Q15, WR_DATA).
CLR_VAL, 16'h0000, value written to every word by a clear sequence (WIDTH bits).

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  reset; one clock, asynchronous assert, active-low
WR_EN  input  1  write request, sampled at rising CLK
WR_ADDR  input  4  write word address
WR_DATA  input  WIDTH  write data
RD_REQ  input  1  read request, sampled at rising CLK
RD_ADDR  input  4  read word address
CLR_REQ  input  1  start clear of all 16 words
SEL  output  4  registered read address, drives mux select
RD_VALID  output  1  one-cycle pulse: mux output holds requested word
BUSY  output  1  high while clear sequence in progress
Q0..Q15  output  WIDTH each  stored words, drive mux inputs IN0..IN15

Behaviour:
- Reset (RST_N=0, asynchronous): Q0..Q15=0, SEL=0, RD_VALID=0, BUSY=0, state=IDLE, clear counter=0. Release is synchronous to the next CLK edge.
- States: IDLE and CLEAR.
- IDLE, CLR_REQ=0:
  - WR_EN=1: Q[WR_ADDR] <= WR_DATA at the sampling edge. Other words unchanged.
  - RD_REQ=1: SEL <= RD_ADDR and RD_VALID <= 1 at the same edge. RD_VALID is 0 at every edge where RD_REQ is not accepted. Read latency is 1 cycle from request edge to valid mux output. SEL holds its value between reads.
  - WR_EN and RD_REQ to the same address at the same edge: the write and the SEL update land together, so the mux shows the NEW data while RD_VALID=1 (write-first).
  - Back-to-back RD_REQ: one RD_VALID pulse per accepted request, continuous high for consecutive requests.
- IDLE, CLR_REQ=1: go to CLEAR, counter=0, BUSY <= 1. CLR_REQ has priority, so WR_EN and RD_REQ in the same cycle are dropped (no write, RD_VALID stays 0, SEL unchanged).
- CLEAR:
  - At each edge, Q[counter] <= CLR_VAL and counter increments. Word k is cleared at the (k+1)th edge after the CLR_REQ edge.
  - At the edge clearing word 15: state <= IDLE, BUSY <= 0, counter <= 0. BUSY is therefore high for exactly 16 cycles.
  - WR_EN, RD_REQ and CLR_REQ are ignored. No writes occur, RD_VALID=0, SEL unchanged. Requestors must hold requests until BUSY=0.
  - Counter is 4 bits and wraps 15 -> 0 at exit. No partial or extra clears.
- Reset asserted mid-CLEAR: immediate return to reset values. The clear is abandoned, and all words read 0 anyway.
- Address width is fixed at 4 bits. All 16 addresses are valid, so there are no out-of-range conditions.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
- Reset: assert RST_N=0 mid-cycle -> Q0..Q15=16'h0000, SEL=0, RD_VALID=0, BUSY=0 immediately, without waiting for CLK.
- Write/read: write 16'hA5A5 to addr 3, then RD_REQ addr 3 -> next cycle SEL=3, RD_VALID=1 for one cycle, Q3=16'hA5A5, all other Q unchanged at 0.
- Write-first collision: WR_EN addr 7 data 16'h1234 plus RD_REQ addr 7 in the same cycle (Q7 previously 16'hFFFF) -> next cycle SEL=7, RD_VALID=1, Q7=16'h1234.
- Clear sequence: preload all words with 16'hBEEF, pulse CLR_REQ -> BUSY high for exactly 16 cycles; Q5 becomes 0 at the 6th edge while Q6 is still 16'hBEEF; after BUSY falls, all Q=0. A WR_EN of 16'h5555 to addr 0 during BUSY is dropped (Q0=0). An RD_REQ during BUSY gives RD_VALID=0.
- Priority: CLR_REQ with WR_EN (addr 2, 16'h7777) and RD_REQ (addr 9) in the same cycle -> no write to Q2, RD_VALID=0, SEL unchanged, clear proceeds normally.
- Reset mid-clear: assert RST_N=0 at clear cycle 8 -> BUSY=0, all Q=0, state IDLE. After release, a write plus read of 16'h00FF at addr 15 works normally.
